// File: rtl/qed_inst_monitor.sv
// Registered RV32I instruction-legality monitor for SQED runs: original-register partition,
// immediate bounds, SIF-commit phase and store budget. Optional properties under QED_MON_ASSUME_EN.
module qed_inst_monitor #(
  parameter int REG_HALF    = 16,
  parameter int LD_IMM_MAX  = 64,
  parameter int ST_IMM7_MAX = 2,
  parameter int MAX_STORES  = 15,
  parameter int CNT_W       = 8,
  parameter int PC_DEP_OK   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      instruction,
  input  logic             sif_commit,
  output logic             out_valid,
  output logic             out_legal,
  output logic [3:0]       out_class,
  output logic [1:0]       phase,
  output logic [7:0]       store_count,
  output logic             viol_sticky,
  output logic [CNT_W-1:0] viol_count,
  output logic [31:0]      first_viol_inst
);

  if (MAX_STORES < 1 || MAX_STORES > 255) begin : g_bad_max_stores
    $error("qed_inst_monitor: MAX_STORES must be within 1..255");
  end

  // Handshake: in_valid qualifies instruction on a rising clk edge; out_valid is in_valid
  // delayed one cycle and there is no backpressure. Result fields hold while out_valid = 0.

  typedef enum logic [1:0] {
    PH_PRE   = 2'd0,
    PH_POST  = 2'd1,
    PH_LIMIT = 2'd2
  } phase_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_NOP    = 7'b1111111;

  localparam logic [31:0]      REG_HALF_U = REG_HALF;
  localparam logic [31:0]      LD_MAX_U   = LD_IMM_MAX;
  localparam logic [31:0]      ST_MAX_U   = ST_IMM7_MAX;
  localparam logic [7:0]       MAX_ST8    = 8'(MAX_STORES);
  localparam logic [CNT_W-1:0] VC_ONE     = 1;
  localparam logic [CNT_W-1:0] VC_MAX     = '1;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  logic rd_ok, rs1_ok, rs2_ok, rd_pc_ok, mem_base_ok;
  assign rd_ok       = ({27'b0, rd}  < REG_HALF_U);
  assign rs1_ok      = ({27'b0, rs1} < REG_HALF_U);
  assign rs2_ok      = ({27'b0, rs2} < REG_HALF_U);
  // PC-dependent writers may only target x0 unless PC_DEP_OK relaxes it.
  assign rd_pc_ok    = (PC_DEP_OK != 0) ? rd_ok : (rd == 5'd0);
  assign mem_base_ok = (rs1 == 5'd0) && (instruction[31:30] == 2'b00);

  phase_e     state_q, state_d;
  logic [7:0] sc_q, sc_d;
  logic [3:0] cls_c;
  logic       legal_c;

  always_comb begin
    cls_c = 4'd0;
    unique case (opcode)
      OP_R: begin
        if (((funct7 == 7'b0000000) ||
             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) &&
            rs1_ok && rs2_ok && rd_ok)
          cls_c = 4'd1;
      end
      OP_I: begin
        if (rs1_ok && rd_ok &&
            ((funct3 == 3'b001 && funct7 == 7'b0000000) ||
             (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) ||
             (funct3 != 3'b001 && funct3 != 3'b101)))
          cls_c = 4'd2;
      end
      OP_B: begin
        if (funct3 != 3'b010 && funct3 != 3'b011 && rs1_ok && rs2_ok)
          cls_c = 4'd3;
      end
      OP_LOAD: begin
        if ((funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
             funct3 == 3'b100 || funct3 == 3'b101) &&
            mem_base_ok && rd_ok && ({20'b0, instruction[31:20]} < LD_MAX_U))
          cls_c = 4'd4;
      end
      OP_STORE: begin
        // Stores are only legal inside the post-commit window, judged on the pre-edge phase.
        if ((funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) &&
            mem_base_ok && rs2_ok && ({25'b0, funct7} < ST_MAX_U) && state_q == PH_POST)
          cls_c = 4'd5;
      end
      OP_JAL:    if (rd_pc_ok) cls_c = 4'd6;
      OP_JALR:   if (funct3 == 3'b000 && rs1_ok && rd_pc_ok) cls_c = 4'd7;
      OP_LUI:    if (rd_ok) cls_c = 4'd8;
      OP_AUIPC:  if (rd_pc_ok) cls_c = 4'd9;
      OP_FENCE:  if (funct3 == 3'b000) cls_c = 4'd10;
      OP_SYSTEM: begin
        if (instruction[31:7] == 25'd0 || instruction[31:7] == 25'h0002000)
          cls_c = 4'd11;
      end
      OP_NOP:    cls_c = 4'd12;
      default:   cls_c = 4'd0;
    endcase
  end

  assign legal_c = (cls_c != 4'd0);

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    unique case (state_q)
      PH_PRE: if (sif_commit) state_d = PH_POST;
      PH_POST: begin
        if (!sif_commit) begin
          state_d = PH_PRE;
          sc_d    = 8'd0;
        end else if (in_valid && cls_c == 4'd5) begin
          sc_d = sc_q + 8'd1;
          if (sc_q + 8'd1 == MAX_ST8) state_d = PH_LIMIT;
        end
      end
      PH_LIMIT: begin
        if (!sif_commit) begin
          state_d = PH_PRE;
          sc_d    = 8'd0;
        end
      end
      default: begin
        state_d = PH_PRE;
        sc_d    = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= PH_PRE;
      sc_q            <= 8'd0;
      out_valid       <= 1'b0;
      out_legal       <= 1'b0;
      out_class       <= 4'd0;
      viol_sticky     <= 1'b0;
      viol_count      <= '0;
      first_viol_inst <= 32'd0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      out_valid <= in_valid;
      if (in_valid) begin
        out_legal <= legal_c;
        out_class <= cls_c;
      end
      if (in_valid && !legal_c) begin
        if (viol_count != VC_MAX) viol_count <= viol_count + VC_ONE;
        if (!viol_sticky) begin
          viol_sticky     <= 1'b1;
          first_viol_inst <= instruction;
        end
      end
    end
  end

  assign phase       = state_q;
  assign store_count = sc_q;

`ifdef QED_MON_ASSUME_EN
  assume_in_legal: assume property (@(posedge clk) disable iff (rst) in_valid |-> legal_c);
  assert_no_viol:  assert property (@(posedge clk) disable iff (rst) !viol_sticky);
`else
  // Plain checker build: no properties.
`endif

endmodule

// File: doc/qed_inst_monitor.md
Name: qed_inst_monitor

Overview:
- Registered, parametrised instruction-legality monitor for SQED formal runs on the RV32I core.
- Classifies each issued instruction against the original-register partition and immediate bounds.
- Tracks the SIF-commit phase and a post-commit store budget with a state machine.
- Produces a registered legal/class result plus sticky violation bookkeeping.
- Sits between the instruction-source driver and the DUT; `sif_commit` is a port, not a hierarchical reference.

Parameters:
- REG_HALF, 16: register partition boundary; every used rs1/rs2/rd must be < REG_HALF.
- LD_IMM_MAX, 64: loads require imm12 < LD_IMM_MAX.
- ST_IMM7_MAX, 2: stores require imm[11:5] < ST_IMM7_MAX.
- MAX_STORES, 15: legal stores allowed per commit window (1..255).
- CNT_W, 8: violation counter width.
- PC_DEP_OK, 0: 1 permits rd != 0 for JAL, JALR and AUIPC; 0 forces rd == 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction presented this cycle.
- instruction  in  32  RV32I encoding.
- sif_commit  in  1  SIF commit level from the DUT.
- out_valid  out  1  in_valid delayed by one cycle.
- out_legal  out  1  registered legality of the instruction.
- out_class  out  4  registered class code.
- phase  out  2  FSM state: 0 PRE, 1 POST, 2 LIMIT.
- store_count  out  8  legal stores counted in the current window.
- viol_sticky  out  1  set on the first illegal valid instruction.
- viol_count  out  CNT_W  illegal valid instructions, saturating.
- first_viol_inst  out  32  encoding of the first illegal instruction.

Behaviour:
- Reset values: all outputs 0; phase = PRE.
- A reset asserted mid-run clears everything on that edge, including an in-flight result (out_valid = 0 next cycle).
- Latency: the result for the instruction sampled at edge N appears after edge N; out_valid follows in_valid exactly. Outputs are held when out_valid = 0.
- Class codes: 0 illegal, 1 R, 2 I, 3 B, 4 LOAD, 5 STORE, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC, 10 FENCE, 11 SYSTEM, 12 NOP (opcode 7'h7F).
- R / I / B / LOAD / STORE / LUI / FENCE / SYSTEM encodings and field rules:
  - Same funct3/funct7 rules as the RV32I base ISA.
  - SLLI/SRLI/SRAI: funct7 restricted to 0000000 or 0100000.
  - LOAD and STORE: rs1 == 0 and instruction[31:30] == 0.
  - SYSTEM: ECALL and EBREAK only, with rs1 = rd = 0.
- Anything not matching a class is code 0, out_legal = 0.
- Phase FSM, evaluated on valid and invalid cycles:
  - PRE -> POST when sif_commit = 1.
  - POST -> LIMIT when a legal store brings store_count to MAX_STORES.
  - POST or LIMIT -> PRE when sif_commit = 0; store_count clears to 0.
- STORE legality by current phase (the pre-edge value):
  - PRE: illegal.
  - POST: legal, store_count++.
  - LIMIT: illegal.
- Simultaneous events: a store in the same cycle sif_commit first rises is judged in PRE, so it is illegal.
- A store that fills the budget is legal; the next store is illegal.
- Violation bookkeeping:
  - On a valid illegal instruction, viol_count++ saturating at 2^CNT_W-1.
  - If viol_sticky was 0, capture first_viol_inst and set viol_sticky.
  - viol_sticky and first_viol_inst are cleared only by rst.
- Width rules: store_count is 8-bit; MAX_STORES > 255 is a parameter error, reported by an elaboration-time check.

Optional Feature:
- Macro: QED_MON_ASSUME_EN.
- When defined:
  - Emits a concurrent assume on posedge clk: in_valid |-> the combinational (pre-register) legal term. This constrains formal stimulus in place of a separate constraint module.
  - Adds an assert that viol_sticky is never 1.
- When undefined: a pure synthesizable checker with no properties; outputs are identical in both builds.

Test Plan:
- rst = 1 for 2 cycles, then in_valid with ADD x1,x2,x3 (0x003100B3) -> next cycle out_valid = 1, out_legal = 1, out_class = 1, viol_count = 0.
- ADD x17,x2,x3 (0x003108B3) -> out_legal = 0, class 0, viol_sticky = 1, first_viol_inst = 0x003108B3. A second illegal instruction leaves first_viol_inst unchanged and viol_count = 2.
- SW x1,0(x0) (0x00102023) with sif_commit = 0 -> illegal. Same instruction with sif_commit = 1 held for 2 cycles (phase = POST) -> legal, class 5, store_count = 1.
- MAX_STORES = 2, POST, three consecutive SW 0x00102023 -> legal, legal, illegal; phase = 2 after the second. sif_commit drops -> phase 0, store_count 0.
- CNT_W = 2, five illegal instructions -> viol_count saturates at 3. NOP 0x0000007F -> legal, class 12.
- rst pulsed while in_valid = 1 with an illegal instruction -> next cycle all outputs 0, phase 0.
